// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the dual-clock FIFO pointer controllers.
package async_fifo_pkg;

  // Default FIFO address width; DEPTH = 2**ADDR_WIDTH.
  localparam int unsigned AddrWidthDefault = 4;

  // Widest pointer the conversion helpers handle.
  localparam int unsigned MaxPtrWidth = 32;

  typedef logic [MaxPtrWidth-1:0] ptr_word_t;

  // Number of FIFO entries for a given address width.
  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Binary to Gray. The result is correct for any width up to MaxPtrWidth:
  // zero-extend the operand and truncate the result back to the same width.
  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary. Bits above the true width must be zero; the low bits of the
  // result are then the binary value for that width.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[MaxPtrWidth-1] = gray[MaxPtrWidth-1];
    for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_wptr_full_if.sv
// Write-domain status bus of the dual-clock FIFO.
// master: pointer/status consumer side; slave: async_fifo_wptr_full.
interface async_fifo_wptr_full_if
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidthDefault
);

  logic                  i_winc;
  logic [ADDR_WIDTH:0]   i_wq2_rptr;
  logic                  i_clr_ovf;
  logic                  o_wen;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [ADDR_WIDTH:0]   o_wptr;
  logic                  o_wfull;
  logic                  o_walmost_full;
  logic [ADDR_WIDTH:0]   o_wfree_cnt;
  logic                  o_overflow;

  modport master (
    output i_winc, i_wq2_rptr, i_clr_ovf,
    input  o_wen, o_waddr, o_wptr, o_wfull, o_walmost_full, o_wfree_cnt, o_overflow
  );

  modport slave (
    input  i_winc, i_wq2_rptr, i_clr_ovf,
    output o_wen, o_waddr, o_wptr, o_wfull, o_walmost_full, o_wfree_cnt, o_overflow
  );

endinterface

// File: rtl/async_fifo_gray2bin.sv
// Combinational Gray-to-binary converter, shared by the read and write controllers.
module async_fifo_gray2bin
  import async_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = AddrWidthDefault + 1
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Zero-extend, convert, truncate back to WIDTH.
  always_comb begin
    bin_o = WIDTH'(gray2bin(MaxPtrWidth'(gray_i)));
  end

endmodule

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer and status controller of the dual-clock FIFO.
// Produces the write address/enable and the Gray write pointer for the read-domain
// synchronizer, and derives full / almost-full / free count / overflow from the
// synchronized read pointer. Status is pessimistic because that pointer lags.
module async_fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = AddrWidthDefault,
  parameter int unsigned AFULL_THRESH = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  async_fifo_wptr_full_if.slave bus
);

  localparam int unsigned     PtrW     = ADDR_WIDTH + 1;
  localparam int unsigned     Depth    = depth_of(ADDR_WIDTH);
  localparam logic [PtrW-1:0] DepthW   = PtrW'(Depth);
  localparam logic            AfullRst = (AFULL_THRESH >= Depth);

  logic [PtrW-1:0] wbin_q, wbin_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] free_q, free_d;
  logic            wfull_q, wfull_d;
  logic            afull_q, afull_d;
  logic            ovf_q, ovf_d;

  logic            wen;
  logic [PtrW-1:0] rbin;
  logic [PtrW-1:0] used;
  logic [PtrW-1:0] rptr_full_cmp;

  async_fifo_gray2bin #(
    .WIDTH (PtrW)
  ) u_rptr_g2b (
    .gray_i (bus.i_wq2_rptr),
    .bin_o  (rbin)
  );

  // Next pointer and status, all computed from the post-write pointer.
  always_comb begin
    wen    = bus.i_winc & ~wfull_q;
    wbin_d = wbin_q + PtrW'(wen);
    wptr_d = PtrW'(bin2gray(MaxPtrWidth'(wbin_d)));

    // Full: write pointer is exactly one lap ahead, i.e. top two Gray bits inverted.
    rptr_full_cmp = {~bus.i_wq2_rptr[PtrW-1:PtrW-2], bus.i_wq2_rptr[PtrW-3:0]};
    wfull_d       = (wptr_d == rptr_full_cmp);

    // Modulo subtraction keeps occupancy correct across pointer wrap.
    used    = wbin_d - rbin;
    free_d  = DepthW - used;
    afull_d = (32'(free_d) <= AFULL_THRESH);

    // Set has priority over clear so a same-cycle overflow is never lost.
    ovf_d = ovf_q;
    if (bus.i_clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (bus.i_winc && wfull_q) begin
      ovf_d = 1'b1;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      free_q  <= DepthW;
      wfull_q <= 1'b0;
      afull_q <= AfullRst;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      free_q  <= free_d;
      wfull_q <= wfull_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  // The Gray pointer leaves straight from its flop; it crosses clock domains.
  assign bus.o_wen          = wen;
  assign bus.o_waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign bus.o_wptr         = wptr_q;
  assign bus.o_wfull        = wfull_q;
  assign bus.o_walmost_full = afull_q;
  assign bus.o_wfree_cnt    = free_q;
  assign bus.o_overflow     = ovf_q;

endmodule

// File: doc/async_fifo_wptr_full.md
Name: async_fifo_wptr_full

Overview:
- Write-domain pointer and status controller for the dual-clock FIFO.
- Generates the memory write address and enable.
- Produces the registered Gray-coded write pointer that feeds the 2-flop synchronizer into the read domain.
- Consumes the read pointer after that synchronizer has brought it into this domain, and from it derives full, almost-full, free-entry count and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 4, FIFO address bits; DEPTH = 2**ADDR_WIDTH.
- AFULL_THRESH, 2, o_walmost_full asserts when free entries <= this value (range 0..DEPTH-1).

Ports:
- clk  in  1  write-domain clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_winc  in  1  write request; one entry per cycle while high.
- i_wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already synchronized into clk.
- i_clr_ovf  in  1  clears o_overflow.
- o_wen  out  1  memory write enable; equals i_winc & ~o_wfull (combinational).
- o_waddr  out  ADDR_WIDTH  memory write address; low bits of the binary write pointer (registered).
- o_wptr  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- o_wfull  out  1  registered full flag.
- o_walmost_full  out  1  registered almost-full flag.
- o_wfree_cnt  out  ADDR_WIDTH+1  registered free-entry count, 0..DEPTH.
- o_overflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (async assert, sync release). Values: wbin=0, o_wptr=0, o_waddr=0, o_wfull=0, o_walmost_full=0 (1 if AFULL_THRESH>=DEPTH), o_wfree_cnt=DEPTH, o_overflow=0.
- wbin_next = wbin + o_wen, modulo 2**(ADDR_WIDTH+1).
- wgray_next = wbin_next ^ (wbin_next >> 1).
- wbin and o_wptr are registered every cycle from the *_next values.
- o_waddr = wbin[ADDR_WIDTH-1:0].
- Full:
  - full_next = (wgray_next == {~i_wq2_rptr[MSB:MSB-1], i_wq2_rptr[MSB-2:0]}).
  - Registered into o_wfull.
  - Full asserts in the cycle after the write that fills the FIFO.
  - Full deasserts the cycle after i_wq2_rptr advances.
- Free count:
  - rbin = gray2bin(i_wq2_rptr).
  - used = (wbin_next - rbin) modulo 2**(ADDR_WIDTH+1).
  - free_next = DEPTH - used.
  - o_wfree_cnt <= free_next.
  - o_walmost_full <= (free_next <= AFULL_THRESH).
- All status is derived from wbin_next, so it includes the write accepted in the current cycle.
- Latency: write accepted at edge N; o_wptr, o_waddr and all flags reflect it after edge N.
- Status is pessimistic because the read pointer lags through the synchronizer. Full is never under-reported; free is never over-reported.
- Write while full: o_wen=0, wbin and o_wptr unchanged, o_overflow <= 1.
- Overflow sticky: o_overflow clears only on i_clr_ovf. If set and clear occur in the same cycle, set wins.
- Wrap-around: the binary pointer rolls from 2**(ADDR_WIDTH+1)-1 to 0, and the Gray pointer follows (single-bit change). Full/free compares must stay correct across the wrap through the MSB difference and modulo subtraction.
- o_wptr changes by at most one bit per cycle. This is mandatory for CDC safety.
- o_wptr must come directly from a flop, with no combinational logic after it.

Decomposition:
- Package async_fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterized by width;
  - constant for the default ADDR_WIDTH;
  - localparam helper for DEPTH.
- Sub-module async_fifo_gray2bin: combinational converter, instantiated here and reused by the read-side controller.
- All pointer and flag registers remain in this module.

Test Plan:
- Reset: hold rst_n=0, then release with i_wq2_rptr=0 -> o_wptr=0, o_waddr=0, o_wfull=0, o_walmost_full=0, o_wfree_cnt=16, o_overflow=0.
- Fill, with i_wq2_rptr=0 and i_winc=1 for 16 cycles:
  - o_waddr steps 0..15 and o_wptr follows Gray 0,1,3,2,6,...;
  - o_wfree_cnt steps 15..0;
  - o_walmost_full rises after the 14th write;
  - o_wfull rises after the 16th write, with o_wptr=5'b11000.
- Overflow: keep i_winc=1 while full for 3 cycles:
  - o_wen=0, o_wptr unchanged, o_overflow=1;
  - pulse i_clr_ovf with i_winc=0 -> o_overflow=0;
  - clear and overflow in the same cycle -> o_overflow stays 1.
- Read advance: while full, set i_wq2_rptr=Gray(4)=5'b00110 -> next cycle o_wfull=0, o_wfree_cnt=4, o_walmost_full=0.
- Wrap: write/read continuously through pointer 31->0 with the read pointer lagging by 16 -> o_wptr goes 5'b10000->5'b00000, o_wfull asserted exactly when 16 entries are outstanding, and never falsely asserted across the wrap.
- Mid-operation reset: with wbin=9 and o_overflow=1, assert rst_n=0 between clock edges -> all outputs return to reset values immediately, without waiting for clk.
